// File: rtl/flt_addsub_seq.sv
// Multi-cycle floating-point add/subtract, one shift per cycle.
// RNE rounding, flush-to-zero, start/done handshake.
module flt_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 5;
  localparam int CAP = MAN_W + 3;
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [EXP_W:0]   E1 = 1;
  localparam logic [CW-1:0]    C1 = 1;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            op_q, op_d;
  logic            sl_q, sl_d, ss_q, ss_d;
  logic [EXP_W:0]  e_q, e_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   ml_q, ml_d, ms_q, ms_d;
  logic            spec_q, spec_d;
  logic            first_q, first_d;
  logic [W-1:0]    sres_q, sres_d;
  logic [W-1:0]    res_q, res_d;
  logic [3:0]      sflg_q, sflg_d;
  logic [3:0]      flg_q, flg_d;
  logic            done_q, done_d;

  logic             sa, sb, za, zb;
  logic             na, nb, ia, ib, swap;
  logic [EXP_W-1:0] ea, eb, dexp;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    wa, wb, sum;
  logic [CW-1:0]    cnt0;

  assign sa   = a_q[W-1];
  assign sb   = b_q[W-1] ^ op_q;
  assign ea   = a_q[MAN_W +: EXP_W];
  assign eb   = b_q[MAN_W +: EXP_W];
  assign za   = (ea == '0);
  assign zb   = (eb == '0);
  assign fa   = za ? '0 : a_q[MAN_W-1:0];
  assign fb   = zb ? '0 : b_q[MAN_W-1:0];
  assign na   = (ea == EONES) && (a_q[MAN_W-1:0] != '0);
  assign nb   = (eb == EONES) && (b_q[MAN_W-1:0] != '0);
  assign ia   = (ea == EONES) && (a_q[MAN_W-1:0] == '0);
  assign ib   = (eb == EONES) && (b_q[MAN_W-1:0] == '0);
  assign wa   = {1'b0, ~za, fa, 3'b000};
  assign wb   = {1'b0, ~zb, fb, 3'b000};
  assign swap = {eb, fb} > {ea, fa};
  assign dexp = swap ? eb - ea : ea - eb;
  assign cnt0 = (32'(dexp) > 32'(CAP)) ? CW'(CAP) : CW'(dexp);
  assign sum  = (sl_q == ss_q) ? ml_q + ms_q : ml_q - ms_q;

  logic [MAN_W+1:0] rsum;
  logic             rup, rinx;
  logic [EXP_W:0]   re;
  logic [MAN_W-1:0] rfrac;

  assign rinx  = |ml_q[2:0];
  assign rup   = ml_q[2] & (ml_q[1] | ml_q[0] | ml_q[3]);
  assign rsum  = {1'b0, ml_q[MW-2:3]}
               + {{(MAN_W+1){1'b0}}, rup};
  assign re    = e_q + {{EXP_W{1'b0}}, rsum[MAN_W+1]};
  assign rfrac = rsum[MAN_W+1] ? rsum[MAN_W:1]
                               : rsum[MAN_W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sl_d    = sl_q;
    ss_d    = ss_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    ml_d    = ml_q;
    ms_d    = ms_q;
    spec_d  = spec_q;
    first_d = first_q;
    sres_d  = sres_q;
    sflg_d  = sflg_q;
    res_d   = res_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_sub;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        spec_d  = 1'b1;
        sflg_d  = '0;
        first_d = 1'b1;
        sl_d    = swap ? sb : sa;
        ss_d    = swap ? sa : sb;
        e_d     = {1'b0, swap ? eb : ea};
        ml_d    = swap ? wb : wa;
        ms_d    = swap ? wa : wb;
        cnt_d   = cnt0;
        state_d = ROUND;
        if (na || nb || (ia && ib && (sa != sb))) begin
          sres_d = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};
          sflg_d = 4'b1000;
        end else if (ia) begin
          sres_d = {sa, EONES, {MAN_W{1'b0}}};
        end else if (ib) begin
          sres_d = {sb, EONES, {MAN_W{1'b0}}};
        end else if (za && zb) begin
          sres_d = {sa & sb, {(W-1){1'b0}}};
        end else begin
          spec_d  = 1'b0;
          state_d = (cnt0 != '0) ? ALIGN : ADD;
        end
      end
      ALIGN: begin
        ms_d  = {1'b0, ms_q[MW-1:2], |ms_q[1:0]};
        cnt_d = cnt_q - C1;
        if (cnt_q == C1) state_d = ADD;
      end
      ADD: begin
        ml_d    = sum;
        state_d = NORM;
      end
      NORM: begin
        first_d = 1'b0;
        if (first_q) begin
          if (ml_q == '0) begin
            spec_d  = 1'b1;
            sres_d  = '0;
            sflg_d  = '0;
            state_d = ROUND;
          end else if (ml_q[MW-1]) begin
            ml_d    = {1'b0, ml_q[MW-1:2], |ml_q[1:0]};
            e_d     = e_q + E1;
            state_d = ROUND;
          end else if (ml_q[MW-2]) begin
            state_d = ROUND;
          end
        end else if (e_q == E1) begin
          // result would be subnormal: flush, keeping the sign
          spec_d  = 1'b1;
          sres_d  = {sl_q, {(W-1){1'b0}}};
          sflg_d  = 4'b0011;
          state_d = ROUND;
        end else begin
          ml_d = ml_q << 1;
          e_d  = e_q - E1;
          if (ml_q[MW-3]) state_d = ROUND;
        end
      end
      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (spec_q) begin
          res_d = sres_q;
          flg_d = sflg_q;
        end else if (re >= {1'b0, EONES}) begin
          res_d = {sl_q, EONES, {MAN_W{1'b0}}};
          flg_d = 4'b0101;
        end else begin
          res_d = {sl_q, re[EXP_W-1:0], rfrac};
          flg_d = {3'b000, rinx};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sl_q    <= 1'b0;
      ss_q    <= 1'b0;
      e_q     <= '0;
      cnt_q   <= '0;
      ml_q    <= '0;
      ms_q    <= '0;
      spec_q  <= 1'b0;
      first_q <= 1'b0;
      sres_q  <= '0;
      sflg_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sl_q    <= sl_d;
      ss_q    <= ss_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      ml_q    <= ml_d;
      ms_q    <= ms_d;
      spec_q  <= spec_d;
      first_q <= first_d;
      sres_q  <= sres_d;
      sflg_q  <= sflg_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = res_q;
  assign flags  = flg_q;
endmodule

// File: tb/tb_flt_addsub_seq.sv
// Directed and model-checked bench for flt_addsub_seq (half format).
// Latency counted in rising edges after the start edge.
module tb_flt_addsub_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  flags;
  int n_cmp = 0;
  int n_bad = 0;

  flt_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_sub(op_sub), .a(a), .b(b), .busy(busy),
    .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic issue(input logic [15:0] ia, ib,
                       input logic is,
                       output logic [15:0] r,
                       output logic [3:0] f,
                       output int n);
    @(negedge clk);
    a = ia; b = ib; op_sub = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    r = result;
    f = flags;
  endtask

  task automatic vec(input string tag,
                     input logic [15:0] ia, ib,
                     input logic is,
                     input logic [15:0] er,
                     input logic [3:0] ef,
                     input int el);
    logic [15:0] r;
    logic [3:0]  f;
    int          n;
    issue(ia, ib, is, r, f, n);
    check({tag, ".res"}, r, er);
    check({tag, ".flg"}, f, ef);
    if (el >= 0) check({tag, ".lat"}, n, el);
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    for (int k = 15; k < e; k++) m = m * 2.0;
    for (int k = e; k < 15; k++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  task automatic model(input logic [15:0] ia, ib,
                       input logic is,
                       output logic [15:0] r,
                       output logic [3:0] f);
    real  s, ax, sc, fl, fr;
    int   e;
    logic sg, sb;
    sb = ib[15] ^ is;
    if (ia[14:10] == 0 && ib[14:10] == 0) begin
      r = {ia[15] & sb, 15'h0}; f = 4'b0000;
      return;
    end
    s = h2r(ia) + h2r({sb, ib[14:0]});
    if (s == 0.0) begin
      r = 16'h0000; f = 4'b0000;
      return;
    end
    sg = (s < 0.0);
    ax = sg ? -s : s;
    if (ax < 1.0 / 16384.0) begin
      r = {sg, 15'h0}; f = 4'b0011;
      return;
    end
    e = 0;
    sc = ax;
    while (sc >= 2.0) begin sc = sc / 2.0; e++; end
    while (sc < 1.0) begin sc = sc * 2.0; e--; end
    sc = sc * 1024.0;
    fl = $floor(sc);
    fr = sc - fl;
    if (fr > 0.5 || (fr == 0.5 && ($rtoi(fl) % 2) == 1))
      fl = fl + 1.0;
    if (fl >= 2048.0) begin fl = 1024.0; e++; end
    if (e > 15) begin
      r = {sg, 5'h1F, 10'h0}; f = 4'b0101;
      return;
    end
    r = {sg, 5'(e + 15), 10'($rtoi(fl) - 1024)};
    f = {3'b000, fr != 0.0};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, er, ia, ib;
    logic [3:0]  f, ef;
    logic        is;
    int          n, cnt, ea, eb;

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.res", result, 0);
    check("rst.flg", flags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    vec("1p1",    16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000, 4);
    @(posedge clk); #1;
    check("1p1.pulse", done, 0);
    check("1p1.hold", result, 16'h4000);
    vec("3m1",    16'h4200, 16'h3C00, 1, 16'h4000, 4'b0000, 5);
    vec("cancel", 16'h3C01, 16'h3C01, 1, 16'h0000, 4'b0000, 4);
    vec("tie",    16'h3C00, 16'h1000, 0, 16'h3C00, 4'b0001, 15);
    vec("ovf",    16'h7BFF, 16'h7BFF, 0, 16'h7C00, 4'b0101, 4);
    vec("lshift", 16'h3C01, 16'h3C00, 1, 16'h1400, 4'b0000, 14);
    vec("unf",    16'h0401, 16'h0400, 1, 16'h0000, 4'b0011, -1);
    vec("infm1",  16'h7C00, 16'h3C00, 1, 16'h7C00, 4'b0000, 2);
    vec("nan",    16'h7C01, 16'h3C00, 0, 16'h7E00, 4'b1000, 2);
    vec("nzero",  16'h8000, 16'h8000, 0, 16'h8000, 4'b0000, 2);
    vec("ninf",   16'h3C00, 16'h7C00, 1, 16'hFC00, 4'b0000, 2);

    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h7C00; b = 16'h7C00; op_sub = 1'b1;
    wait_done(n);
    check("b2b.lat1", n, 4);
    check("b2b.res1", result, 16'h4000);
    check("b2b.flg1", flags, 0);
    check("b2b.idle", busy, 0);
    a = 16'h4200; b = 16'h3C00; op_sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy", busy, 1);
    wait_done(n);
    check("b2b.lat2", n, 5);
    check("b2b.res2", result, 16'h4400);

    vec("invalid", 16'h7C00, 16'h7C00, 1, 16'h7E00, 4'b1000, 2);

    @(negedge clk);
    a = 16'h5000; b = 16'h1000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort.busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.res", result, 0);
    check("abort.flg", flags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort.no_done", cnt, 0);

    for (int i = 0; i < 1500; i++) begin
      ea = int'($urandom_range(30, 0));
      if ($urandom_range(1, 0) == 1)
        eb = ea + int'($urandom_range(4, 0)) - 2;
      else
        eb = int'($urandom_range(30, 0));
      if (eb < 0) eb = 0;
      if (eb > 30) eb = 30;
      ia = {1'($urandom), 5'(ea), 10'($urandom)};
      ib = {1'($urandom), 5'(eb), 10'($urandom)};
      is = 1'($urandom);
      model(ia, ib, is, er, ef);
      issue(ia, ib, is, r, f, n);
      check($sformatf("rnd%0d.res a=%h b=%h s=%0d", i, ia, ib, is),
            r, er);
      check($sformatf("rnd%0d.flg", i), f, ef);
      check($sformatf("rnd%0d.lat_ok", i), n <= 29, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
